// File: rtl/sqrt_pipeline_scheduler.sv
// -----------------------------------------------------------------------------
// sqrt_pipeline_scheduler
//
// Flow-control front end for an unstalled sqrt_remainder stage chain
// (RADICAND_WIDTH/2 stages, 2 clk per stage, so LATENCY = RADICAND_WIDTH clk
// from pipe_integer to pipe_result/pipe_remainder).
//
// - Radicands enter through a valid/ready handshake, one launch per clk.
// - A valid shift line follows each op through the chain; when the op leaves
//   the chain its result/remainder is captured into a first-word-fall-through
//   output FIFO.
// - Admission is credit based: an op is accepted only if a FIFO slot is
//   guaranteed for it (FIFO_DEPTH - fifo_count - inflight > 0), so a result
//   can never be dropped even though the chain cannot stall.
// - Flush sequencing: RUN -> DRAIN on a (re-armed) flush_req, DRAIN -> IDLE
//   once nothing is in flight or buffered, with a one-clk flush_done pulse.
//
// Optional feature macro: SQRT_SCHED_TAG_EN
//   When defined, adds in_tag/out_tag (TAG_WIDTH bits). The tag travels beside
//   the data in a LATENCY+1 delay line, is stored in the FIFO and returned
//   with its result. When undefined, no tag ports, logic or storage exist.
// -----------------------------------------------------------------------------
module sqrt_pipeline_scheduler #(
  parameter int RADICAND_WIDTH = 8,
  parameter int FIFO_DEPTH     = 10
`ifdef SQRT_SCHED_TAG_EN
  ,
  parameter int TAG_WIDTH      = 4
`endif
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [RADICAND_WIDTH-1:0]       in_radicand,
  output logic [RADICAND_WIDTH-1:0]       pipe_integer,
  input  logic [RADICAND_WIDTH/2-1:0]     pipe_result,
  input  logic [RADICAND_WIDTH/2+1:0]     pipe_remainder,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [RADICAND_WIDTH/2-1:0]     out_result,
  output logic [RADICAND_WIDTH/2+1:0]     out_remainder,
  input  logic                            flush_req,
  output logic                            flush_done,
  output logic                            busy
`ifdef SQRT_SCHED_TAG_EN
  ,
  input  logic [TAG_WIDTH-1:0]            in_tag,
  output logic [TAG_WIDTH-1:0]            out_tag
`endif
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int LATENCY = RADICAND_WIDTH;
  localparam int RES_W   = RADICAND_WIDTH / 2;
  localparam int REM_W   = RES_W + 2;
  // Both counters are bounded by FIFO_DEPTH; one spare bit keeps their sum
  // representable without overflow.
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DATA_W  = RES_W + REM_W;
`ifdef SQRT_SCHED_TAG_EN
  localparam int ENTRY_W = DATA_W + TAG_WIDTH;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               armed_q, armed_d;       // flush_req must return to 0 before it can trigger again
  logic               flush_done_q, flush_done_d;

  // ---------------------------------------------------------------------------
  // Launch / valid line / FIFO state
  // ---------------------------------------------------------------------------
  logic [RADICAND_WIDTH-1:0] pipe_integer_q;
  logic                      launch_vld_q;     // valid bit of the launch register
  logic [LATENCY-1:0]        vld_q;            // vld_q[LATENCY-1] marks valid chain output
  logic [CNT_W-1:0]          inflight_q;
  logic [CNT_W-1:0]          fifo_count_q;
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [ENTRY_W-1:0]        fifo_mem [FIFO_DEPTH];

  logic                      accept;
  logic                      capture;
  logic                      pop;
  logic [CNT_W-1:0]          occupied;
  logic                      has_credit;
  logic [ENTRY_W-1:0]        wr_entry;
  logic [ENTRY_W-1:0]        rd_entry;

  // ---------------------------------------------------------------------------
  // Handshakes and credit check (from registered counts only, so a pop frees
  // its credit from the following clk)
  // ---------------------------------------------------------------------------
  assign occupied   = fifo_count_q + inflight_q;
  assign has_credit = (occupied < DEPTH_CNT);
  assign in_ready   = (state_q == ST_RUN) && has_credit;
  assign accept     = in_valid && in_ready;
  assign capture    = vld_q[LATENCY-1];
  assign out_valid  = (fifo_count_q != '0);
  assign pop        = out_valid && out_ready;
  assign busy       = (inflight_q != '0) || (fifo_count_q != '0);
  assign flush_done = flush_done_q;
  assign pipe_integer = pipe_integer_q;

  // State register for the control FSM and its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b1;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Next-state logic: IDLE always advances, RUN waits for an armed flush,
  // DRAIN waits until nothing is in flight or buffered.
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    flush_done_d = 1'b0;
    if (!flush_req) begin
      armed_d = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush_req && armed_q) begin
          state_d = ST_DRAIN;
          armed_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if ((inflight_q == '0) && (fifo_count_q == '0)) begin
          state_d      = ST_IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Launch register: pipe_integer takes the accepted radicand and otherwise holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_integer_q <= '0;
      launch_vld_q   <= 1'b0;
    end else begin
      launch_vld_q <= accept;
      if (accept) begin
        pipe_integer_q <= in_radicand;
      end
    end
  end

  // Valid shift line: one bit per chain clk, so the MSB lines up with the
  // chain output belonging to the launched radicand.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], launch_vld_q};
    end
  end

  // In-flight counter: incremented on accept, decremented on capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
    end else begin
      unique case ({accept, capture})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional tag delay line (not reset: stale tags are never captured since
  // their valid bits are 0)
  // ---------------------------------------------------------------------------
`ifdef SQRT_SCHED_TAG_EN
  logic [TAG_WIDTH-1:0] tag_line_q [LATENCY+1];

  // First tag stage sits beside the launch register.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_line_q[0] <= in_tag;
    end
  end

  for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_tag_line
    // Plain shift stage tracking the chain.
    always_ff @(posedge clk) begin
      tag_line_q[gi] <= tag_line_q[gi-1];
    end
  end

  assign wr_entry = {tag_line_q[LATENCY], pipe_result, pipe_remainder};
  assign out_tag  = rd_entry[ENTRY_W-1 -: TAG_WIDTH];
`else
  assign wr_entry = {pipe_result, pipe_remainder};
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------

  // Storage write on capture; contents are not reset, only the pointers/count.
  always_ff @(posedge clk) begin
    if (capture) begin
      fifo_mem[wr_ptr_q] <= wr_entry;
    end
  end

  // Pointers wrap modulo FIFO_DEPTH; count is unchanged on simultaneous push+pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (capture) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      unique case ({capture, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // Head entry is presented combinationally; it only changes on a pop, so the
  // outputs hold while out_valid=1 and out_ready=0.
  assign rd_entry      = fifo_mem[rd_ptr_q];
  assign out_result    = rd_entry[DATA_W-1 -: RES_W];
  assign out_remainder = rd_entry[REM_W-1:0];

  // Credit admission must make a push into a full FIFO impossible.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!reset)
    !(capture && (fifo_count_q == DEPTH_CNT))
  );

endmodule
